rd_scoreboard: RTL and testbench

Destination-register scoreboard for the Vi in-order pipeline, the producer-side counterpart of the bypass controller. It records the destination register and latency class of every instruction leaving decode. It counts each write down until the result is forwardable (EXE, C or M5) and until it retires in W. It tells decode, one cycle ahead of the bypass network, whether each source operand is clean, will be bypassed, or must stall.

---
 rtl/vi_pkg.sv | 38 +++
 rtl/sb_entry.sv | 63 ++++++
 rtl/rd_scoreboard.sv | 77 +++++++
 tb/tb_rd_scoreboard.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/vi_pkg.sv
// Shared definitions for the Vi pipeline: latency classes, fixed issue-to-available
// latencies and the scoreboard countdown width.
package vi_pkg;

   localparam int CW = 3;

   typedef enum logic [1:0] {
      CLS_ALU  = 2'd0,
      CLS_LOAD = 2'd1,
      CLS_MULT = 2'd2,
      CLS_RSVD = 2'd3
   } lat_class_e;

   localparam int LAT_FWD_ALU  = 1;
   localparam int LAT_FWD_LOAD = 2;
   localparam int LAT_FWD_MULT = 5;
   localparam int LAT_RET_ALU  = 3;
   localparam int LAT_RET_LOAD = 3;
   localparam int LAT_RET_MULT = 6;

   // The reserved class behaves exactly like an ALU op.
   function automatic int lat_fwd(lat_class_e cls);
      case (cls)
         CLS_LOAD: return LAT_FWD_LOAD;
         CLS_MULT: return LAT_FWD_MULT;
         default:  return LAT_FWD_ALU;
      endcase
   endfunction

   function automatic int lat_ret(lat_class_e cls);
      case (cls)
         CLS_LOAD: return LAT_RET_LOAD;
         CLS_MULT: return LAT_RET_MULT;
         default:  return LAT_RET_ALU;
      endcase
   endfunction

endpackage

// File: rtl/sb_entry.sv
// One scoreboard entry: pending-write flag plus forward and retire countdowns for a
// single architectural register.
module sb_entry
   import vi_pkg::*;
#(
   parameter int W = CW
) (
   input  logic         clk_i,
   input  logic         rsn_i,
   input  logic         flush_i,
   input  logic         hold_i,
   input  logic         issue_i,
   input  lat_class_e   class_i,
   output logic         busy_o,
   output logic [W-1:0] fwd_cnt_o,
   output logic [W-1:0] ret_cnt_o
);

   logic         busy_q, busy_d;
   logic [W-1:0] fwd_q, fwd_d;
   logic [W-1:0] ret_q, ret_d;

   // The forward counter is read one cycle after issue, so it starts one below the
   // latency; the retire counter covers the full latency and clears busy at 1.
   always_comb begin
      busy_d = busy_q;
      fwd_d  = fwd_q;
      ret_d  = ret_q;
      if (issue_i) begin
         busy_d = 1'b1;
         fwd_d  = W'(lat_fwd(class_i) - 1);
         ret_d  = W'(lat_ret(class_i));
      end else if (!hold_i && busy_q) begin
         if (ret_q == W'(1)) begin
            busy_d = 1'b0;
            fwd_d  = '0;
            ret_d  = '0;
         end else begin
            if (fwd_q != '0) fwd_d = fwd_q - W'(1);
            if (ret_q != '0) ret_d = ret_q - W'(1);
         end
      end
   end

   // NOTE: state flops use non-blocking assignments so every entry samples the same
   // pre-edge values; all three are reset because hazard logic reads them directly.
   always_ff @(posedge clk_i) begin
      if (rsn_i || flush_i) begin
         busy_q <= 1'b0;
         fwd_q  <= '0;
         ret_q  <= '0;
      end else begin
         busy_q <= busy_d;
         fwd_q  <= fwd_d;
         ret_q  <= ret_d;
      end
   end

   assign busy_o    = busy_q;
   assign fwd_cnt_o = fwd_q;
   assign ret_cnt_o = ret_q;

endmodule

// File: rtl/rd_scoreboard.sv
// Destination-register scoreboard: tracks in-flight writes and tells decode, one
// cycle ahead of the bypass network, whether each source is clean, forwarded or stalled.
module rd_scoreboard #(
   parameter int NREGS = 32,
   parameter int CW    = vi_pkg::CW
) (
   input  logic             clk_i,
   input  logic             rsn_i,
   input  logic             dec_valid_i,
   input  logic             dec_wr_en_i,
   input  logic [4:0]       dec_wr_addr_i,
   input  logic [1:0]       dec_class_i,
   input  logic [4:0]       dec_read_addr_a_i,
   input  logic [4:0]       dec_read_addr_b_i,
   input  logic             dec_read_en_a_i,
   input  logic             dec_read_en_b_i,
   input  logic             back_stall_i,
   input  logic             flush_i,
   output logic             stall_core_o,
   output logic             fwd_a_o,
   output logic             fwd_b_o,
   output logic [NREGS-1:0] busy_o
);

   vi_pkg::lat_class_e cls;
   logic               busy_w    [NREGS];
   logic [CW-1:0]      fwd_cnt_w [NREGS];
   logic [CW-1:0]      ret_cnt_w [NREGS];
   logic [NREGS-1:1]   issue_vec;
   logic               hit_a, hit_b, raw_a, raw_b, waw, kill, issue;

   assign cls = vi_pkg::lat_class_e'(dec_class_i);

   // x0 has no entry; its slot reads as permanently idle.
   assign busy_w[0]    = 1'b0;
   assign fwd_cnt_w[0] = '0;
   assign ret_cnt_w[0] = '0;

   for (genvar i = 1; i < NREGS; i++) begin : g_entry
      assign issue_vec[i] = issue && (dec_wr_addr_i == 5'(i));

      sb_entry #(.W(CW)) u_entry (
         .clk_i     (clk_i),
         .rsn_i     (rsn_i),
         .flush_i   (flush_i),
         .hold_i    (back_stall_i),
         .issue_i   (issue_vec[i]),
         .class_i   (cls),
         .busy_o    (busy_w[i]),
         .fwd_cnt_o (fwd_cnt_w[i]),
         .ret_cnt_o (ret_cnt_w[i])
      );
   end

   always_comb begin
      busy_o = '0;
      for (int i = 0; i < NREGS; i++) busy_o[i] = busy_w[i];
   end

   assign hit_a = dec_read_en_a_i && (dec_read_addr_a_i != '0) && busy_w[dec_read_addr_a_i];
   assign hit_b = dec_read_en_b_i && (dec_read_addr_b_i != '0) && busy_w[dec_read_addr_b_i];
   assign raw_a = hit_a && (fwd_cnt_w[dec_read_addr_a_i] != '0);
   assign raw_b = hit_b && (fwd_cnt_w[dec_read_addr_b_i] != '0);

   // A younger write must not retire earlier than the one already in flight.
   assign waw = dec_wr_en_i && (dec_wr_addr_i != '0) && busy_w[dec_wr_addr_i]
             && (CW'(vi_pkg::lat_ret(cls)) <= ret_cnt_w[dec_wr_addr_i]);

   assign kill         = flush_i || rsn_i;
   assign stall_core_o = dec_valid_i && (raw_a || raw_b || waw) && !kill;
   assign fwd_a_o      = hit_a && !raw_a && !kill;
   assign fwd_b_o      = hit_b && !raw_b && !kill;

   assign issue = dec_valid_i && dec_wr_en_i && (dec_wr_addr_i != '0)
               && !stall_core_o && !back_stall_i;

endmodule

// File: tb/tb_rd_scoreboard.sv
// Directed bench for rd_scoreboard: hand-derived expectations for forwarding, RAW/WAW
// stalls, back-end freeze, x0 handling, flush and mid-countdown reset.
module tb_rd_scoreboard;

   logic        clk = 1'b0;
   logic        rsn;
   logic        dec_valid, dec_wr_en, dec_read_en_a, dec_read_en_b;
   logic [4:0]  dec_wr_addr, dec_read_addr_a, dec_read_addr_b;
   logic [1:0]  dec_class;
   logic        back_stall, flush;
   logic        stall_core, fwd_a, fwd_b;
   logic [31:0] busy;

   int n_cmp = 0;
   int n_err = 0;

   rd_scoreboard #(.NREGS(32), .CW(3)) dut (
      .clk_i             (clk),
      .rsn_i             (rsn),
      .dec_valid_i       (dec_valid),
      .dec_wr_en_i       (dec_wr_en),
      .dec_wr_addr_i     (dec_wr_addr),
      .dec_class_i       (dec_class),
      .dec_read_addr_a_i (dec_read_addr_a),
      .dec_read_addr_b_i (dec_read_addr_b),
      .dec_read_en_a_i   (dec_read_en_a),
      .dec_read_en_b_i   (dec_read_en_b),
      .back_stall_i      (back_stall),
      .flush_i           (flush),
      .stall_core_o      (stall_core),
      .fwd_a_o           (fwd_a),
      .fwd_b_o           (fwd_b),
      .busy_o            (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Start a new cycle: inputs change just after the edge, checks follow 2 ns later.
   task automatic cyc(input logic v, input logic we, input logic [4:0] wa, input logic [1:0] cl,
                      input logic ea, input logic [4:0] ra, input logic eb, input logic [4:0] rb,
                      input logic bs, input logic fl);
      @(posedge clk);
      #1;
      dec_valid = v;  dec_wr_en = we; dec_wr_addr = wa; dec_class = cl;
      dec_read_en_a = ea; dec_read_addr_a = ra;
      dec_read_en_b = eb; dec_read_addr_b = rb;
      back_stall = bs; flush = fl;
      #2;
   endtask

   task automatic idle();
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      rsn = 1'b1;
      dec_valid = 0; dec_wr_en = 0; dec_wr_addr = 0; dec_class = 0;
      dec_read_en_a = 0; dec_read_addr_a = 0; dec_read_en_b = 0; dec_read_addr_b = 0;
      back_stall = 0; flush = 0;
      repeat (2) @(posedge clk);
      #1 rsn = 1'b0;
      #2;
      check("reset busy",  busy, 32'h0);
      check("reset stall", {31'b0, stall_core}, 32'h0);
      check("reset fwd",   {30'b0, fwd_a, fwd_b}, 32'h0);

      // ALU x5, then add x6,x5,x0 right behind it: EXE bypass, no stall.
      cyc(1, 1, 5'd5, 2'd0, 0, 0, 0, 0, 0, 0);
      check("alu issue stall", {31'b0, stall_core}, 32'h0);
      cyc(1, 1, 5'd6, 2'd0, 1, 5'd5, 1, 5'd0, 0, 0);
      check("alu dep stall", {31'b0, stall_core}, 32'h0);
      check("alu dep fwd_a", {31'b0, fwd_a}, 32'h1);
      check("alu dep fwd_b x0", {31'b0, fwd_b}, 32'h0);
      check("alu busy n+1", busy, 32'h0000_0020);
      idle(); check("alu busy n+2", busy, 32'h0000_0060);
      idle(); check("alu busy n+3", busy, 32'h0000_0060);
      idle(); check("alu busy n+4", busy, 32'h0000_0040);
      idle(); check("alu busy n+5", busy, 32'h0);

      // MULT x7: dependent stalls four cycles, forwarded on the fifth.
      cyc(1, 1, 5'd7, 2'd2, 0, 0, 0, 0, 0, 0);
      for (int k = 1; k <= 4; k++) begin
         cyc(1, 0, 0, 0, 1, 5'd7, 0, 0, 0, 0);
         check($sformatf("mult raw stall n+%0d", k), {30'b0, stall_core, fwd_a}, 32'h2);
      end
      cyc(1, 0, 0, 0, 1, 5'd7, 1, 5'd7, 0, 0);
      check("mult n+5 stall", {31'b0, stall_core}, 32'h0);
      check("mult n+5 fwd_a/b", {30'b0, fwd_a, fwd_b}, 32'h3);
      idle(); check("mult busy n+6", busy, 32'h0000_0080);
      idle(); check("mult busy n+7", busy, 32'h0);

      // LOAD x8 with the back end frozen for three cycles.
      cyc(1, 1, 5'd8, 2'd1, 0, 0, 0, 0, 0, 0);
      for (int k = 1; k <= 3; k++) begin
         cyc(1, 0, 0, 0, 1, 5'd8, 0, 0, 1, 0);
         check($sformatf("load frozen stall n+%0d", k), {30'b0, stall_core, fwd_a}, 32'h2);
      end
      cyc(1, 0, 0, 0, 1, 5'd8, 0, 0, 0, 0);
      check("load n+4 stall", {30'b0, stall_core, fwd_a}, 32'h2);
      cyc(1, 0, 0, 0, 1, 5'd8, 0, 0, 0, 0);
      check("load n+5 fwd", {30'b0, stall_core, fwd_a}, 32'h1);
      idle(); check("load busy n+6", busy, 32'h0000_0100);
      idle(); check("load busy n+7", busy, 32'h0);

      // Back stall blocks an otherwise clean issue.
      cyc(1, 1, 5'd10, 2'd0, 0, 0, 0, 0, 1, 0);
      check("bstall clean stall", {31'b0, stall_core}, 32'h0);
      idle(); check("bstall no issue", busy, 32'h0);

      // MULT x9, then a reserved-class (ALU-latency) write to x9 waits out WAW.
      cyc(1, 1, 5'd9, 2'd2, 0, 0, 0, 0, 0, 0);
      for (int k = 1; k <= 4; k++) begin
         cyc(1, 1, 5'd9, 2'd3, 0, 0, 0, 0, 0, 0);
         check($sformatf("waw stall n+%0d", k), {31'b0, stall_core}, 32'h1);
      end
      cyc(1, 1, 5'd9, 2'd3, 0, 0, 0, 0, 0, 0);
      check("waw accept n+5", {31'b0, stall_core}, 32'h0);
      idle(); check("waw busy n+6", busy, 32'h0000_0200);
      idle(); check("waw busy n+7", busy, 32'h0000_0200);
      idle(); check("waw busy n+8", busy, 32'h0000_0200);
      idle(); check("waw busy n+9", busy, 32'h0);

      // x0 as MULT destination and as both sources.
      cyc(1, 1, 5'd0, 2'd2, 1, 5'd0, 1, 5'd0, 0, 0);
      check("x0 stall", {29'b0, stall_core, fwd_a, fwd_b}, 32'h0);
      cyc(1, 1, 5'd0, 2'd2, 1, 5'd0, 1, 5'd0, 0, 0);
      check("x0 busy", busy, 32'h0);
      check("x0 stall again", {31'b0, stall_core}, 32'h0);

      // Three writes in flight, then flush.
      cyc(1, 1, 5'd11, 2'd2, 0, 0, 0, 0, 0, 0);
      cyc(1, 1, 5'd12, 2'd1, 0, 0, 0, 0, 0, 0);
      cyc(1, 1, 5'd13, 2'd0, 0, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 1, 5'd11, 1, 5'd13, 0, 0);
      check("pre-flush busy", busy, 32'h0000_3800);
      check("pre-flush hazards", {29'b0, stall_core, fwd_a, fwd_b}, 32'h5);
      cyc(1, 1, 5'd14, 2'd0, 1, 5'd11, 1, 5'd13, 0, 1);
      check("flush cycle outputs", {29'b0, stall_core, fwd_a, fwd_b}, 32'h0);
      check("flush cycle busy", busy, 32'h0000_3800);
      cyc(1, 0, 0, 0, 1, 5'd11, 1, 5'd12, 0, 0);
      check("post-flush busy", busy, 32'h0);
      check("post-flush stall", {29'b0, stall_core, fwd_a, fwd_b}, 32'h0);

      // Reset in the middle of a MULT countdown.
      cyc(1, 1, 5'd15, 2'd2, 0, 0, 0, 0, 0, 0);
      idle();
      cyc(1, 0, 0, 0, 1, 5'd15, 0, 0, 0, 0);
      check("mult15 pending", {busy[15], stall_core}, 2'b11);
      rsn = 1'b1;
      cyc(1, 0, 0, 0, 1, 5'd15, 0, 0, 0, 0);
      rsn = 1'b0;
      check("reset mid-count busy", busy, 32'h0);
      check("reset mid-count stall", {30'b0, stall_core, fwd_a}, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
